// File: rtl/player_cmd_issuer.sv
// Player instruction word source: queues damage/heal/attack commands, issues each for one cycle,
// and fills the gaps with the current move word. Optional damage i-frames via `DAMAGE_IFRAME_EN.
module player_cmd_issuer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int INIT_HP       = 100,
  parameter int INIT_ATK      = 10,
  parameter int IFRAME_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_req,
  input  logic        dmg_valid,
  input  logic [7:0]  dmg_amt,
  output logic        dmg_ready,
  input  logic        heal_valid,
  input  logic [7:0]  heal_amt,
  output logic        heal_ready,
  input  logic        atk_valid,
  input  logic        atk_set,
  input  logic [7:0]  atk_amt,
  output logic        atk_ready,
  input  logic [3:0]  btn,
  output logic [15:0] instruction,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(IFRAME_CYCLES + 1);
  localparam logic [15:0] HP_WORD  = {4'h6, 8'(INIT_HP), 4'h0};
  localparam logic [15:0] ATK_WORD = {4'h4, 8'(INIT_ATK), 4'h0};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_INIT_HP, S_INIT_ATK} state_t;

  state_t        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          fifo_full, fifo_empty, accept_ok, dmg_takes, push, pop;
  logic [15:0]   push_word, move_word;
  logic [TW-1:0] timer_v;
  logic          iframe_active;

  assign iframe_active = (timer_v != '0);

  always_comb begin
    fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    fifo_empty = (cnt_q == '0);
    accept_ok  = !init_req && (state_q != S_INIT_HP) && (state_q != S_INIT_ATK);
    // A damage request inside the i-frame window is swallowed and lets heal/atk compete.
    dmg_takes  = dmg_valid && !iframe_active;
    dmg_ready  = accept_ok && dmg_valid && (iframe_active || !fifo_full);
    heal_ready = accept_ok && !fifo_full && heal_valid && !dmg_takes;
    atk_ready  = accept_ok && !fifo_full && atk_valid && !heal_valid && !dmg_takes;
    push       = (dmg_ready && !iframe_active) || heal_ready || atk_ready;
    if (dmg_ready && !iframe_active) begin
      push_word = {4'h2, dmg_amt, 4'h0};
    end else if (heal_ready) begin
      push_word = {4'h1, heal_amt, 4'h0};
    end else if (atk_ready) begin
      push_word = {(atk_set ? 4'h4 : 4'h3), atk_amt, 4'h0};
    end else begin
      push_word = 16'h0000;
    end
  end

  always_comb begin
    if (btn[0]) begin
      move_word = 16'h5000;
    end else if (btn[1]) begin
      move_word = 16'h5010;
    end else if (btn[2]) begin
      move_word = 16'h5020;
    end else if (btn[3]) begin
      move_word = 16'h5030;
    end else begin
      move_word = 16'h0000;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = move_word;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          instr_d = mem_q[rd_q];
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE:    state_d = S_GAP;
      S_GAP:      state_d = S_IDLE;
      S_INIT_HP: begin
        instr_d = ATK_WORD;
        state_d = S_INIT_ATK;
      end
      S_INIT_ATK: state_d = S_GAP;
      default:    state_d = S_IDLE;
    endcase
    if (init_req) begin
      state_d = S_INIT_HP;
      instr_d = HP_WORD;
      pop     = 1'b0;
    end else begin
      pop = pop;
    end
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (init_req) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_word;
        wr_d        = wr_q + AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= 16'h0000;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

`ifdef DAMAGE_IFRAME_EN
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    drop_q, drop_d;

  always_comb begin
    timer_d = timer_q;
    drop_d  = drop_q;
    if (init_req) begin
      timer_d = '0;
    end else if (dmg_ready && !iframe_active) begin
      timer_d = TW'(IFRAME_CYCLES);
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end else begin
      timer_d = timer_q;
    end
    if (dmg_ready && iframe_active && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'h01;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      drop_q  <= 8'h00;
    end else begin
      timer_q <= timer_d;
      drop_q  <= drop_d;
    end
  end

  assign timer_v  = timer_q;
  assign drop_cnt = drop_q;
`else
  assign timer_v  = '0;
  assign drop_cnt = 8'h00;
`endif

  assign instruction = instr_q;
  assign busy        = (cnt_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_player_cmd_issuer.sv
// Bench for player_cmd_issuer: directed vector table, hand sequences for fill/flush and i-frames,
// then random traffic against a timestamp/queue reference model.
module tb_player_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int IFR   = 8;
  localparam logic [15:0] HP_W  = 16'h6640;
  localparam logic [15:0] ATK_W = 16'h40A0;

  logic clk = 1'b0;
  logic reset, init_req, dmg_valid, heal_valid, atk_valid, atk_set;
  logic [7:0] dmg_amt, heal_amt, atk_amt;
  logic [3:0] btn;
  logic dmg_ready, heal_ready, atk_ready, busy;
  logic [15:0] instruction;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  player_cmd_issuer #(.FIFO_DEPTH(DEPTH), .INIT_HP(100), .INIT_ATK(10), .IFRAME_CYCLES(IFR)) dut (
    .clk(clk), .reset(reset), .init_req(init_req),
    .dmg_valid(dmg_valid), .dmg_amt(dmg_amt), .dmg_ready(dmg_ready),
    .heal_valid(heal_valid), .heal_amt(heal_amt), .heal_ready(heal_ready),
    .atk_valid(atk_valid), .atk_set(atk_set), .atk_amt(atk_amt), .atk_ready(atk_ready),
    .btn(btn), .instruction(instruction), .busy(busy), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic init; logic dv; logic [7:0] da; logic hv; logic [7:0] ha;
    logic av; logic aset; logic [7:0] aa; logic [3:0] b;
    logic e_dr; logic e_hr; logic e_ar; logic [15:0] e_ins; logic e_busy;
  } vec_t;

  vec_t tbl [24];
  vec_t blank;
  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] mq [$];
  int last_issue, last_init, last_dmg, drop_m;
  int heal_seen, dmg_seen, m_heal_acc;
  logic last_heal_ready;

  function automatic vec_t mk(input logic init, input logic dv, input logic [7:0] da,
                              input logic hv, input logic [7:0] ha, input logic av,
                              input logic aset, input logic [7:0] aa, input logic [3:0] b,
                              input logic e_dr, input logic e_hr, input logic e_ar,
                              input logic [15:0] e_ins, input logic e_busy);
    vec_t v;
    v.init = init; v.dv = dv; v.da = da; v.hv = hv; v.ha = ha; v.av = av; v.aset = aset;
    v.aa = aa; v.b = b; v.e_dr = e_dr; v.e_hr = e_hr; v.e_ar = e_ar; v.e_ins = e_ins;
    v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [15:0] move_of(input logic [3:0] b);
    if (b[0]) return 16'h5000;
    if (b[1]) return 16'h5010;
    if (b[2]) return 16'h5020;
    if (b[3]) return 16'h5030;
    return 16'h0000;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input vec_t v);
    init_req = v.init; dmg_valid = v.dv; dmg_amt = v.da; heal_valid = v.hv; heal_amt = v.ha;
    atk_valid = v.av; atk_set = v.aset; atk_amt = v.aa; btn = v.b;
  endtask

  // One clock: check readies before the edge, advance the model, check outputs after the edge.
  task automatic step(input bit use_tbl, input vec_t v);
    int t;
    logic blk, full, iframe, dtake, e_dr, e_hr, e_ar, issue, e_busy;
    logic [15:0] e_ins;
    t = cyc + 1;
    #1;
    blk  = init_req || (t == last_init + 1) || (t == last_init + 2);
    full = (mq.size() == DEPTH);
`ifdef DAMAGE_IFRAME_EN
    iframe = (t > last_dmg) && (t <= last_dmg + IFR);
`else
    iframe = 1'b0;
`endif
    dtake = dmg_valid && !iframe;
    e_dr  = dmg_valid && !blk && (iframe || !full);
    e_hr  = heal_valid && !blk && !full && !dtake;
    e_ar  = atk_valid && !blk && !full && !dtake && !heal_valid;
    check("dmg_ready", dmg_ready, e_dr);
    check("heal_ready", heal_ready, e_hr);
    check("atk_ready", atk_ready, e_ar);
    if (use_tbl) begin
      check("tbl_dmg_ready", dmg_ready, v.e_dr);
      check("tbl_heal_ready", heal_ready, v.e_hr);
      check("tbl_atk_ready", atk_ready, v.e_ar);
    end
    last_heal_ready = heal_ready;
    @(posedge clk);
    cyc = t;
    issue = !init_req && (mq.size() > 0) && (t >= last_issue + 3) && (t >= last_init + 4);
    if (init_req) e_ins = HP_W;
    else if (t == last_init + 1) e_ins = ATK_W;
    else if (issue) e_ins = mq.pop_front();
    else e_ins = move_of(btn);
    if (issue) last_issue = t;
    if (init_req) begin
      mq.delete();
      last_init = t;
      last_dmg  = -1000;
    end else begin
      if (e_dr && !iframe) begin
        mq.push_back({4'h2, dmg_amt, 4'h0});
        last_dmg = t;
      end else if (e_dr && iframe && drop_m < 255) begin
        drop_m++;
      end
      if (e_hr) begin
        mq.push_back({4'h1, heal_amt, 4'h0});
        m_heal_acc++;
      end
      if (e_ar) mq.push_back({(atk_set ? 4'h4 : 4'h3), atk_amt, 4'h0});
    end
    e_busy = (mq.size() > 0) || (t - last_issue < 2) || (t - last_init < 3);
    #1;
    check("instruction", instruction, e_ins);
    check("busy", busy, e_busy);
    check("drop_cnt", drop_cnt, 16'(drop_m));
    if (use_tbl) begin
      check("tbl_instruction", instruction, v.e_ins);
      check("tbl_busy", busy, v.e_busy);
    end
    if (instruction[15:12] == 4'h1) heal_seen++;
    if (instruction[15:12] == 4'h2) dmg_seen++;
  endtask

  initial begin
    int flushed, exp_dmg, exp_drop;
    logic saw_drop;
    blank = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 0);
    // init sequence, single damage, buttons with a heal, then all three sources at once
    tbl[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h6640, 1);
    tbl[1]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h40A0, 1);
    tbl[2]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 1);
    tbl[3]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 0);
    tbl[4]  = mk(0, 1, 8'h05, 0, 8'h00, 0, 0, 8'h00, 4'h0, 1, 0, 0, 16'h0000, 1);
    tbl[5]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h2050, 1);
    tbl[6]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 1);
    tbl[7]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 0);
    tbl[8]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h6, 0, 0, 0, 16'h5010, 0);
    tbl[9]  = mk(0, 0, 8'h00, 1, 8'h01, 0, 0, 8'h00, 4'h6, 0, 1, 0, 16'h5010, 1);
    tbl[10] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h6, 0, 0, 0, 16'h1010, 1);
    tbl[11] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h6, 0, 0, 0, 16'h5010, 1);
    tbl[12] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h6, 0, 0, 0, 16'h5010, 0);
    tbl[13] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 0);
    tbl[14] = mk(0, 1, 8'h05, 1, 8'h14, 1, 1, 8'h07, 4'h0, 1, 0, 0, 16'h0000, 1);
    tbl[15] = mk(0, 0, 8'h00, 1, 8'h14, 1, 1, 8'h07, 4'h0, 0, 1, 0, 16'h2050, 1);
    tbl[16] = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h07, 4'h0, 0, 0, 1, 16'h0000, 1);
    tbl[17] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 1);
    tbl[18] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h1140, 1);
    tbl[19] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 1);
    tbl[20] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 1);
    tbl[21] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h4070, 1);
    tbl[22] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 1);
    tbl[23] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 16'h0000, 0);

    reset = 1'b1;
    set_in(blank);
    repeat (3) @(posedge clk);
    #1;
    check("reset_instruction", instruction, 16'h0000);
    check("reset_busy", busy, 1'b0);
    check("reset_dmg_ready", dmg_ready, 1'b0);
    check("reset_heal_ready", heal_ready, 1'b0);
    check("reset_atk_ready", atk_ready, 1'b0);
    check("reset_drop_cnt", drop_cnt, 16'h0000);
    reset = 1'b0;
    last_issue = -100; last_init = -100; last_dmg = -1000; drop_m = 0;
    heal_seen = 0; dmg_seen = 0; m_heal_acc = 0;

    for (int i = 0; i < 24; i++) begin
      set_in(tbl[i]);
      step(1'b1, tbl[i]);
    end

    // Fill the queue with heals, then flush it with init_req while it drains.
    set_in(blank);
    heal_seen = 0; m_heal_acc = 0; saw_drop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      heal_valid = 1'b1;
      heal_amt   = 8'(i + 1);
      step(1'b0, blank);
      if (!last_heal_ready) saw_drop = 1'b1;
    end
    heal_valid = 1'b0;
    repeat (3) step(1'b0, blank);
    flushed  = mq.size();
    init_req = 1'b1;
    step(1'b0, blank);
    init_req = 1'b0;
    repeat (12) step(1'b0, blank);
    check("heal_ready_drops_at_full", saw_drop, 1'b1);
    check("flush_left_entries", (flushed > 0) ? 16'h0001 : 16'h0000, 16'h0001);
    check("heal_emitted", 16'(heal_seen), 16'(m_heal_acc - flushed));

    // Damage twice three cycles apart, then once more well after the window.
    dmg_seen = 0;
`ifdef DAMAGE_IFRAME_EN
    exp_dmg = 2; exp_drop = drop_m + 1;
`else
    exp_dmg = 3; exp_drop = drop_m;
`endif
    dmg_amt = 8'h05;
    dmg_valid = 1'b1; step(1'b0, blank);
    dmg_valid = 1'b0; repeat (2) step(1'b0, blank);
    dmg_valid = 1'b1; step(1'b0, blank);
    dmg_valid = 1'b0; repeat (10) step(1'b0, blank);
    dmg_valid = 1'b1; step(1'b0, blank);
    dmg_valid = 1'b0; repeat (6) step(1'b0, blank);
    check("iframe_dmg_emitted", 16'(dmg_seen), 16'(exp_dmg));
    check("iframe_drop_cnt", drop_cnt, 16'(exp_drop));

    for (int i = 0; i < 600; i++) begin
      init_req   = ($urandom_range(0, 39) == 0);
      dmg_valid  = ($urandom_range(0, 3) == 0);
      heal_valid = ($urandom_range(0, 2) == 0);
      atk_valid  = ($urandom_range(0, 2) == 0);
      atk_set    = 1'($urandom_range(0, 1));
      dmg_amt    = 8'($urandom);
      heal_amt   = 8'($urandom);
      atk_amt    = 8'($urandom);
      btn        = 4'($urandom);
      step(1'b0, blank);
    end
    set_in(blank);
    repeat (4) step(1'b0, blank);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
